// File: rtl/cdc_sched_pkg.sv
// Shared definitions for the CDC bus scheduler slice.
// Contents:
//   sched_state_e  scheduler FSM state encoding (IDLE / HOLD / GAP)
//   clog2          ceiling log2 used for derived widths
//   tag_width      width of the requester index (tx_tag)
//   cnt_width      width of the HOLD/GAP down-counter, sized so it never wraps
package cdc_sched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A single requester would give a zero-width tag; keep at least one bit.
  function automatic int tag_width(input int num_req);
    return (num_req < 2) ? 1 : clog2(num_req);
  endfunction

  // The counter is loaded with HOLD_CYCLES-1 or GAP_CYCLES-1, so it must hold
  // the larger of the two.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int largest;
    largest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (clog2(largest + 1) < 1) ? 1 : clog2(largest + 1);
  endfunction

endpackage

// File: rtl/cdc_bus_scheduler_if.sv
// Requester-side bus of the CDC bus scheduler.
// Signals:
//   req         per-requester request level
//   req_data    packed requester words, word k at [k*BUS_WIDTH +: BUS_WIDTH]
//   grant       one-hot, single-cycle acceptance pulse
//   Unsync_bus  held data word presented to the synchronizer
//   tx_tag      index of the requester owning Unsync_bus
//   bus_enable  transfer qualifier presented to the synchronizer
//   busy        high while a transfer is in HOLD or GAP
// Modports:
//   master  requester side (drives req/req_data)
//   slave   scheduler side (drives grant and the synchronizer outputs)
interface cdc_bus_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8
);
  import cdc_sched_pkg::*;

  localparam int TAG_W = tag_width(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           grant;
  logic [BUS_WIDTH-1:0]         Unsync_bus;
  logic [TAG_W-1:0]             tx_tag;
  logic                         bus_enable;
  logic                         busy;

  modport master (
    output req, req_data,
    input  grant, Unsync_bus, tx_tag, bus_enable, busy
  );

  modport slave (
    input  req, req_data,
    output grant, Unsync_bus, tx_tag, bus_enable, busy
  );

endinterface

// File: rtl/cdc_bus_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// The search starts at ptr and wraps through NUM_REQ-1 back to 0; the first
// asserted request found wins. The pointer register itself lives in the caller.
// Ports:
//   req        in   per-requester request level
//   ptr        in   index where the search starts
//   win_valid  out  some request is asserted
//   win_idx    out  index of the winning requester (0 when none)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic               win_valid,
  output logic [TAG_W-1:0]   win_idx
);

  logic [TAG_W-1:0] cand_idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = TAG_W'((int'(ptr) + i) % NUM_REQ);
      if (!win_valid && req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/cdc_bus_scheduler.sv
// Source-domain scheduler that shares one multi-flop bus synchronizer between
// NUM_REQ requesters. A round-robin winner's word and index are captured, then
// bus_enable is held high for HOLD_CYCLES and low for GAP_CYCLES while the word
// stays stable, so the destination enable synchronizer sees exactly one clean
// rising edge per transfer.
// Ports:
//   CLK  in  source clock
//   RST  in  asynchronous active-high reset
//   bus  slave side of cdc_bus_scheduler_if (req/req_data in; grant,
//        Unsync_bus, tx_tag, bus_enable, busy out, all registered)
module cdc_bus_scheduler
  import cdc_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 6,
  parameter int GAP_CYCLES  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  cdc_bus_scheduler_if.slave    bus
);

  localparam int TAG_W = tag_width(NUM_REQ);
  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TAG_W-1:0]      ptr_q, ptr_d;
  logic [BUS_WIDTH-1:0]  bus_q, bus_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;

  logic                  win_valid;
  logic [TAG_W-1:0]      win_idx;
  logic [BUS_WIDTH-1:0]  sel_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_arb (
    .req       (bus.req),
    .ptr       (ptr_q),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  // Mux out the winner's word with a compare per requester rather than a
  // variable part-select, keeping the index arithmetic out of the data path.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == TAG_W'(k)) begin
        sel_word = bus.req_data[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Requests are only looked at in IDLE, so a request raised during HOLD/GAP
  // (including in the grant cycle) can never produce a second grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    bus_d   = bus_q;
    tag_d   = tag_q;
    grant_d = '0;
    en_d    = en_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          bus_d   = sel_word;
          tag_d   = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          ptr_d   = (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every output is a flop, so reset clears bus_enable immediately and a
  // transfer in flight is simply abandoned.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      bus_q   <= '0;
      tag_q   <= '0;
      grant_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      bus_q   <= bus_d;
      tag_q   <= tag_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.Unsync_bus = bus_q;
  assign bus.tx_tag     = tag_q;
  assign bus.bus_enable = en_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_cdc_bus_scheduler.sv
// Directed bench for cdc_bus_scheduler.
// busA drives the default configuration (HOLD 6, GAP 3); busB drives a second
// instance with HOLD 1, GAP 1. Inputs change on the falling edge and outputs
// are sampled on the falling edge, half a cycle away from the active edge.
module tb_cdc_bus_scheduler;

  logic CLK;
  logic RST;

  int compareCount;
  int mismatchCount;

  cdc_bus_scheduler_if #(.NUM_REQ(4), .BUS_WIDTH(8)) busA ();
  cdc_bus_scheduler_if #(.NUM_REQ(4), .BUS_WIDTH(8)) busB ();

  cdc_bus_scheduler #(
    .NUM_REQ(4), .BUS_WIDTH(8), .HOLD_CYCLES(6), .GAP_CYCLES(3)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (busA)
  );

  cdc_bus_scheduler #(
    .NUM_REQ(4), .BUS_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1)
  ) dutShort (
    .CLK (CLK),
    .RST (RST),
    .bus (busB)
  );

  // 10 ns clock: rising edges at 5, 15, 25 ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the stimulus sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] reqVec);
    busA.req = reqVec;
  endtask

  int expCh[5] = '{0, 1, 2, 3, 0};

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    RST           = 1'b0;
    busA.req      = '0;
    busA.req_data = {8'h33, 8'hA5, 8'h22, 8'h11};
    busB.req      = '0;
    busB.req_data = {8'h44, 8'h55, 8'h66, 8'h77};

    // Reset state, checked before any clock edge.
    #1 RST = 1'b1;
    #2;
    checkOutput("rst_grant", 32'(busA.grant), 32'h0);
    checkOutput("rst_en", 32'(busA.bus_enable), 32'h0);
    checkOutput("rst_busy", 32'(busA.busy), 32'h0);
    checkOutput("rst_bus", 32'(busA.Unsync_bus), 32'h0);
    checkOutput("rst_tag", 32'(busA.tx_tag), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Single request on channel 2: one grant pulse, 6 enable-high cycles,
    // 3 enable-low cycles, word and tag stable all 9 cycles.
    @(negedge CLK);
    applyStimulus(4'b0100);
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      if (i == 0) applyStimulus(4'b0000);
      checkOutput($sformatf("t2_grant_%0d", i), 32'(busA.grant),
                  (i == 0) ? 32'h4 : 32'h0);
      checkOutput($sformatf("t2_en_%0d", i), 32'(busA.bus_enable),
                  (i < 6) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t2_busy_%0d", i), 32'(busA.busy), 32'h1);
      checkOutput($sformatf("t2_bus_%0d", i), 32'(busA.Unsync_bus), 32'hA5);
      checkOutput($sformatf("t2_tag_%0d", i), 32'(busA.tx_tag), 32'h2);
    end
    @(negedge CLK);
    checkOutput("t2_idle_busy", 32'(busA.busy), 32'h0);

    // Pointer now 3: channel 3 wins over channel 0, then the pointer wraps
    // to 0 and channel 0 is served one period later.
    applyStimulus(4'b1001);
    @(negedge CLK);
    checkOutput("t4_grant3", 32'(busA.grant), 32'h8);
    checkOutput("t4_tag3", 32'(busA.tx_tag), 32'h3);
    checkOutput("t4_bus3", 32'(busA.Unsync_bus), 32'h33);
    applyStimulus(4'b0001);
    repeat (9) @(negedge CLK);
    @(negedge CLK);
    checkOutput("t4_grant0", 32'(busA.grant), 32'h1);
    checkOutput("t4_tag0", 32'(busA.tx_tag), 32'h0);
    checkOutput("t4_bus0", 32'(busA.Unsync_bus), 32'h11);
    applyStimulus(4'b0000);
    repeat (9) @(negedge CLK);
    checkOutput("t4_idle_busy", 32'(busA.busy), 32'h0);

    // Reset asserted in the third HOLD cycle clears everything immediately.
    applyStimulus(4'b0010);
    @(negedge CLK);
    checkOutput("t1_grant", 32'(busA.grant), 32'h2);
    applyStimulus(4'b0000);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("t1_pre_en", 32'(busA.bus_enable), 32'h1);
    checkOutput("t1_pre_tag", 32'(busA.tx_tag), 32'h1);
    #2 RST = 1'b1;
    #1;
    checkOutput("t1_rst_en", 32'(busA.bus_enable), 32'h0);
    checkOutput("t1_rst_grant", 32'(busA.grant), 32'h0);
    checkOutput("t1_rst_busy", 32'(busA.busy), 32'h0);
    checkOutput("t1_rst_bus", 32'(busA.Unsync_bus), 32'h0);
    checkOutput("t1_rst_tag", 32'(busA.tx_tag), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("t1_post_busy", 32'(busA.busy), 32'h0);
    checkOutput("t1_post_en", 32'(busA.bus_enable), 32'h0);

    // All requesters pending with pointer 0: strict rotation 0,1,2,3,0 at
    // 10-cycle spacing.
    applyStimulus(4'b1111);
    for (int t = 0; t < 5; t++) begin
      if (t > 0) repeat (9) @(negedge CLK);
      @(negedge CLK);
      checkOutput($sformatf("t3_grant_%0d", t), 32'(busA.grant),
                  32'(1) << expCh[t]);
      checkOutput($sformatf("t3_tag_%0d", t), 32'(busA.tx_tag), 32'(expCh[t]));
    end
    applyStimulus(4'b0000);
    repeat (9) @(negedge CLK);
    checkOutput("t3_idle_busy", 32'(busA.busy), 32'h0);

    // A request pulsed only during HOLD is ignored; the same request raised
    // in IDLE is granted on the next cycle.
    applyStimulus(4'b0010);
    @(negedge CLK);
    checkOutput("t5_grant1", 32'(busA.grant), 32'h2);
    applyStimulus(4'b0000);
    @(negedge CLK);
    @(negedge CLK);
    applyStimulus(4'b0100);
    @(negedge CLK);
    applyStimulus(4'b0000);
    checkOutput("t5_hold_grant", 32'(busA.grant), 32'h0);
    checkOutput("t5_hold_tag", 32'(busA.tx_tag), 32'h1);
    repeat (6) @(negedge CLK);
    checkOutput("t5_idle_busy", 32'(busA.busy), 32'h0);
    checkOutput("t5_idle_grant", 32'(busA.grant), 32'h0);
    checkOutput("t5_idle_tag", 32'(busA.tx_tag), 32'h1);
    applyStimulus(4'b0100);
    @(negedge CLK);
    checkOutput("t5_grant2", 32'(busA.grant), 32'h4);
    checkOutput("t5_tag2", 32'(busA.tx_tag), 32'h2);
    applyStimulus(4'b0000);
    repeat (9) @(negedge CLK);

    // HOLD 1 / GAP 1 instance: enable high one cycle, low one, 3-cycle period.
    busB.req = 4'b0001;
    @(negedge CLK);
    checkOutput("t6_grant_a", 32'(busB.grant), 32'h1);
    checkOutput("t6_en_a", 32'(busB.bus_enable), 32'h1);
    checkOutput("t6_busy_a", 32'(busB.busy), 32'h1);
    checkOutput("t6_bus_a", 32'(busB.Unsync_bus), 32'h77);
    @(negedge CLK);
    checkOutput("t6_en_gap", 32'(busB.bus_enable), 32'h0);
    checkOutput("t6_busy_gap", 32'(busB.busy), 32'h1);
    checkOutput("t6_grant_gap", 32'(busB.grant), 32'h0);
    @(negedge CLK);
    checkOutput("t6_busy_idle", 32'(busB.busy), 32'h0);
    checkOutput("t6_en_idle", 32'(busB.bus_enable), 32'h0);
    @(negedge CLK);
    checkOutput("t6_grant_b", 32'(busB.grant), 32'h1);
    checkOutput("t6_en_b", 32'(busB.bus_enable), 32'h1);
    busB.req = 4'b0000;
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
